// File: rtl/comparator_serial_seq.sv
// Bit-serial MSB-first unsigned magnitude comparator.
// The operands are latched on an accepted start. One bit is examined per clock.
// All six flags are registered together when the DONE state is entered.
module comparator_serial_seq #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             neq,
  output logic             lt,
  output logic             gt,
  output logic             lte,
  output logic             gte
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             dec_q, dec_d;
  logic             gt_acc_q, gt_acc_d;
  // Flag bit order: {eq, neq, lt, gt, lte, gte}. All zero means no valid result yet.
  logic [5:0]       flg_q, flg_d;

  logic bit_diff, dec_nx, gt_nx;
  logic f_eq, f_lt, f_gt;

  // Decision for the bit at idx. The first differing bit wins and later bits are ignored.
  always_comb begin
    bit_diff = a_q[idx_q] ^ b_q[idx_q];
    dec_nx   = dec_q | bit_diff;
    gt_nx    = dec_q ? gt_acc_q : (bit_diff & a_q[idx_q]);
    f_eq     = ~dec_nx;
    f_lt     = dec_nx & ~gt_nx;
    f_gt     = dec_nx & gt_nx;
  end

  // Next-state logic. The cycle count is fixed and does not depend on the data.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    dec_d    = dec_q;
    gt_acc_d = gt_acc_q;
    flg_d    = flg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          idx_d    = IW'(WIDTH - 1);
          dec_d    = 1'b0;
          gt_acc_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        dec_d    = dec_nx;
        gt_acc_d = gt_nx;
        idx_d    = idx_q - IW'(1);
        if (idx_q == '0) begin
          flg_d   = {f_eq, ~f_eq, f_lt, f_gt, f_lt | f_eq, f_gt | f_eq};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any compare in flight and clears the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      dec_q    <= 1'b0;
      gt_acc_q <= 1'b0;
      flg_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      dec_q    <= dec_d;
      gt_acc_q <= gt_acc_d;
      flg_q    <= flg_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign {eq, neq, lt, gt, lte, gte} = flg_q;

endmodule

// File: tb/tb_comparator_serial_seq.sv
// Directed bench for the serial comparator.
// One instance is built with WIDTH=3 and a second with WIDTH=1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_comparator_serial_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       st3 = 1'b0, st1 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy3, done3, eq3, neq3, lt3, gt3, lte3, gte3;
  logic       busy1, done1, eq1, neq1, lt1, gt1, lte1, gte1;

  int errors = 0;
  int checks = 0;

  // Expected flag vectors {eq, neq, lt, gt, lte, gte}
  localparam logic [5:0] F_GT = 6'b010101;
  localparam logic [5:0] F_LT = 6'b011010;
  localparam logic [5:0] F_EQ = 6'b100011;
  localparam logic [5:0] F_0  = 6'b000000;

  always #5 clk = ~clk;

  comparator_serial_seq #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .eq(eq3), .neq(neq3), .lt(lt3), .gt(gt3),
    .lte(lte3), .gte(gte3)
  );

  comparator_serial_seq #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .eq(eq1), .neq(neq1), .lt(lt1), .gt(gt1),
    .lte(lte1), .gte(gte1)
  );

  wire [5:0] f3 = {eq3, neq3, lt3, gt3, lte3, gte3};
  wire [5:0] f1 = {eq1, neq1, lt1, gt1, lte1, gte1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    // Reset is asserted mid-cycle, and the outputs must clear before any edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy3", busy3, 0);
    chk("rst_done3", done3, 0);
    chk("rst_flags3", f3, F_0);
    chk("rst_flags1", {busy1, done1, f1}, 0);
    nx(); nx();
    rst_n = 1'b1;
    nx();

    // 5 vs 3: a single start pulse gives a gt result.
    a3 = 3'd5; b3 = 3'd3; st3 = 1'b1;
    nx(); st3 = 1'b0;                       // after E0
    chk("g_busy_e0", {busy3, done3}, 2'b10);
    nx(); chk("g_busy_e1", {busy3, done3}, 2'b10);
    nx(); chk("g_busy_e2", {busy3, done3}, 2'b10);
    chk("g_flags_pre", f3, F_0);
    nx(); chk("g_done_e3", {busy3, done3}, 2'b01);
    chk("g_flags", f3, F_GT);
    repeat (5) nx();
    chk("g_hold_done", done3, 0);
    chk("g_hold_flags", f3, F_GT);

    // 2 vs 6, then 7 vs 7, issued back to back with start held high.
    a3 = 3'd2; b3 = 3'd6; st3 = 1'b1;
    nx(); a3 = 3'd7; b3 = 3'd7;            // after E0
    for (int k = 1; k <= 8; k++) begin
      nx();
      if (k == 5) st3 = 1'b0;
      chk($sformatf("bb_done_e%0d", k), done3, (k == 3 || k == 8));
      if (k == 3) chk("bb_flags1", f3, F_LT);
      if (k == 7) chk("bb_hold", f3, F_LT);
      if (k == 8) chk("bb_flags2", f3, F_EQ);
    end
    nx();

    // 4 vs 4 with the operands disturbed and start pulsed during SHIFT and DONE.
    a3 = 3'd4; b3 = 3'd4; st3 = 1'b1;
    nx(); st3 = 1'b0; a3 = 3'd0; b3 = 3'd7; // after E0
    nx(); st3 = 1'b1;                       // after E1, still in SHIFT
    nx(); st3 = 1'b0;                       // after E2
    nx();                                   // after E3, in DONE
    chk("ig_done", done3, 1);
    chk("ig_flags", f3, F_EQ);
    st3 = 1'b1;
    nx(); st3 = 1'b0;                       // after E4
    for (int k = 4; k <= 8; k++) begin
      chk($sformatf("ig_idle_e%0d", k), {busy3, done3}, 2'b00);
      if (k < 8) nx();
    end
    chk("ig_flags_hold", f3, F_EQ);

    // Reset during SHIFT abandons the compare.
    a3 = 3'd6; b3 = 3'd1; st3 = 1'b1;
    nx(); st3 = 1'b0;
    nx(); nx();                             // after E2
    rst_n = 1'b0;
    #1;
    chk("mr_busy", busy3, 0);
    chk("mr_flags", f3, F_0);
    nx(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nx();
      chk($sformatf("mr_nodone%0d", k), {busy3, done3, f3}, 0);
    end
    a3 = 3'd1; b3 = 3'd6; st3 = 1'b1;
    nx(); st3 = 1'b0;
    nx(); nx();
    chk("mr2_notyet", done3, 0);
    nx();
    chk("mr2_done", done3, 1);
    chk("mr2_flags", f3, F_LT);

    // WIDTH=1 instance: 1 vs 0, then 0 vs 0, with a repeat period of three edges.
    a1 = 1'b1; b1 = 1'b0; st1 = 1'b1;
    nx(); a1 = 1'b0; b1 = 1'b0;             // after E0
    chk("w1_busy", {busy1, done1}, 2'b10);
    for (int k = 1; k <= 4; k++) begin
      nx();
      if (k == 3) st1 = 1'b0;
      chk($sformatf("w1_done_e%0d", k), done1, (k == 1 || k == 4));
      if (k == 1) chk("w1_gt", f1, F_GT);
      if (k == 4) chk("w1_eq", f1, F_EQ);
    end
    nx();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
